// File: rtl/dice_cgra_tid_issuer_if.sv
// Bundle between the dispatch controller, the issuer and the TID pipe.
// master: dispatch/pipe side driving controls; slave: the issuer.
interface dice_cgra_tid_issuer_if #(
    parameter int TOTAL_TID   = 512,
    parameter int TID_WIDTH   = $clog2(TOTAL_TID),
    parameter int MAX_LATENCY = 32,
    parameter int LAT_WIDTH   = $clog2(MAX_LATENCY + 1)
);
    logic                 start;
    logic                 abort;
    logic [TID_WIDTH:0]   tid_count;
    logic [TOTAL_TID-1:0] active_mask;
    logic [LAT_WIDTH-1:0] latency;
    logic                 stall;
    logic [TID_WIDTH-1:0] out_tid;
    logic                 out_valid;
    logic                 pipe_clr;
    logic                 busy;
    logic                 done;
    logic [TID_WIDTH:0]   issued_cnt;

    modport master (
        output start, abort, tid_count, active_mask, latency, stall,
        input  out_tid, out_valid, pipe_clr, busy, done, issued_cnt
    );

    modport slave (
        input  start, abort, tid_count, active_mask, latency, stall,
        output out_tid, out_valid, pipe_clr, busy, done, issued_cnt
    );
endinterface

// File: rtl/dice_cgra_tid_issuer.sv
// Source end of the CGRA thread-ID pipe: walks a thread block issuing one
// tid per cycle, then waits out the pipe latency and pulses done.
// Ports: clk, rst_n (sync, active low), bus (slave modport: start/abort,
// tid_count, active_mask, latency, stall in; out_tid, out_valid, pipe_clr,
// busy, done, issued_cnt out -- all outputs registered).
module dice_cgra_tid_issuer #(
    parameter int TOTAL_TID   = 512,
    parameter int TID_WIDTH   = $clog2(TOTAL_TID),
    parameter int MAX_LATENCY = 32,
    parameter int LAT_WIDTH   = $clog2(MAX_LATENCY + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dice_cgra_tid_issuer_if.slave    bus
);
    localparam int CNT_W = TID_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_n;

    logic [TOTAL_TID-1:0] mask_q, mask_n;
    logic [CNT_W-1:0]     count_q, count_n;
    logic [LAT_WIDTH-1:0] lat_q, lat_n;
    logic [LAT_WIDTH-1:0] drain_q, drain_n;
    logic [TID_WIDTH-1:0] cursor_q, cursor_n;

    logic [TID_WIDTH-1:0] out_tid_n;
    logic                 out_valid_n;
    logic                 pipe_clr_n;
    logic                 busy_n;
    logic                 done_n;
    logic [CNT_W-1:0]     issued_n;

    logic [CNT_W-1:0]     cnt_sat;
    logic [LAT_WIDTH-1:0] lat_clamp;
    logic                 last;
    logic                 go;

    assign cnt_sat = (bus.tid_count > CNT_W'(TOTAL_TID))
                   ? CNT_W'(TOTAL_TID) : bus.tid_count;
    assign lat_clamp = (bus.latency > LAT_WIDTH'(MAX_LATENCY))
                     ? LAT_WIDTH'(MAX_LATENCY) : bus.latency;
    assign last = ({1'b0, cursor_q} == count_q - CNT_W'(1));
    // abort beats a simultaneous start in IDLE
    assign go = bus.start && !bus.abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (go) begin
                    state_n = (cnt_sat == '0) ? DONE : CLR;
                end
            end
            CLR: begin
                state_n = bus.abort ? IDLE : ISSUE;
            end
            ISSUE: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (!bus.stall && last) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (drain_q == '0) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        mask_n      = mask_q;
        count_n     = count_q;
        lat_n       = lat_q;
        drain_n     = drain_q;
        cursor_n    = cursor_q;
        out_tid_n   = bus.out_tid;
        out_valid_n = 1'b0;
        pipe_clr_n  = 1'b0;
        issued_n    = bus.issued_cnt;
        busy_n      = (state_n != IDLE);
        done_n      = (state_n == DONE);
        unique case (state)
            IDLE: begin
                if (go) begin
                    issued_n = '0;
                    if (cnt_sat != '0) begin
                        mask_n     = bus.active_mask;
                        count_n    = cnt_sat;
                        lat_n      = lat_clamp;
                        pipe_clr_n = 1'b1;
                    end
                end
            end
            CLR: begin
                if (bus.abort) begin
                    pipe_clr_n = 1'b1;
                end else begin
                    cursor_n = '0;
                end
            end
            ISSUE: begin
                if (bus.abort) begin
                    pipe_clr_n = 1'b1;
                end else if (!bus.stall) begin
                    out_tid_n   = cursor_q;
                    out_valid_n = mask_q[cursor_q];
                    if (mask_q[cursor_q]) begin
                        issued_n = bus.issued_cnt + CNT_W'(1);
                    end
                    // hold on the last tid so the cursor never wraps
                    if (last) begin
                        drain_n = lat_q;
                    end else begin
                        cursor_n = cursor_q + TID_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (bus.abort) begin
                    pipe_clr_n = 1'b1;
                end else if (drain_q != '0) begin
                    drain_n = drain_q - LAT_WIDTH'(1);
                end
            end
            DONE: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q         <= '0;
            count_q        <= '0;
            lat_q          <= '0;
            drain_q        <= '0;
            cursor_q       <= '0;
            bus.out_tid    <= '0;
            bus.out_valid  <= 1'b0;
            bus.pipe_clr   <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.issued_cnt <= '0;
        end else begin
            mask_q         <= mask_n;
            count_q        <= count_n;
            lat_q          <= lat_n;
            drain_q        <= drain_n;
            cursor_q       <= cursor_n;
            bus.out_tid    <= out_tid_n;
            bus.out_valid  <= out_valid_n;
            bus.pipe_clr   <= pipe_clr_n;
            bus.busy       <= busy_n;
            bus.done       <= done_n;
            bus.issued_cnt <= issued_n;
        end
    end
endmodule

// File: tb/tb_dice_cgra_tid_issuer.sv
// Bench for dice_cgra_tid_issuer: table rows, hand sequences for abort and
// reset, and random runs checked against a cycle-walk reference model.
module tb_dice_cgra_tid_issuer;
    localparam int TT  = 512;
    localparam int TW  = 9;
    localparam int ML  = 32;
    localparam int LW  = 6;
    localparam int MAXC = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    dice_cgra_tid_issuer_if #(
        .TOTAL_TID(TT), .TID_WIDTH(TW),
        .MAX_LATENCY(ML), .LAT_WIDTH(LW)
    ) bus ();

    dice_cgra_tid_issuer #(
        .TOTAL_TID(TT), .TID_WIDTH(TW),
        .MAX_LATENCY(ML), .LAT_WIDTH(LW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int          cnt;
        logic [511:0] msk;
        int          lat;
        int          st0;
        int          stlen;
        int          exp_done;
        int          exp_issued;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.stall = 1'b0;
    endtask

    // Runs one block from IDLE; the model walks issue cycles from the
    // rules: decisions start two cycles after start, a stalled cycle
    // consumes no tid, and done lands L+2 cycles after the last decision.
    task automatic run_case(input int cnt, input logic [511:0] msk,
                            input int lat, input int st0, input int stlen,
                            input int pct, output int done_obs,
                            output int issued_obs);
        bit  stall_pat[MAXC];
        bit  exp_v[MAXC];
        int  exp_tid[MAXC];
        int  n, l, t, idx, dcyc, run_iss;
        n = (cnt > TT) ? TT : cnt;
        l = (lat > ML) ? ML : lat;
        for (int i = 0; i < MAXC; i++) begin
            stall_pat[i] = ((i >= st0) && (i < st0 + stlen)) ||
                           (int'($urandom_range(99)) < pct);
            exp_v[i] = 1'b0;
            exp_tid[i] = 0;
        end
        if (n == 0) begin
            dcyc = 1;
        end else begin
            t = 2;
            idx = 0;
            while (idx < n && t < MAXC - 40) begin
                if (!stall_pat[t]) begin
                    exp_v[t + 1] = msk[idx];
                    exp_tid[t + 1] = idx;
                    idx++;
                end
                t++;
            end
            dcyc = (t - 1) + 2 + l;
        end
        done_obs = -1;
        run_iss = 0;
        for (int cyc = 0; cyc <= dcyc + 1; cyc++) begin
            if (cyc > 0) begin
                if (exp_v[cyc]) run_iss++;
                if (bus.done && done_obs < 0) done_obs = cyc;
                chk("out_valid", bus.out_valid, exp_v[cyc]);
                if (exp_v[cyc]) chk("out_tid", bus.out_tid, exp_tid[cyc]);
                chk("done", bus.done, cyc == dcyc);
                chk("busy", bus.busy, cyc <= dcyc);
                chk("pipe_clr", bus.pipe_clr, (cyc == 1) && (n > 0));
                chk("issued_run", bus.issued_cnt, run_iss);
            end
            bus.start = (cyc == 0);
            bus.abort = 1'b0;
            bus.tid_count = (TW + 1)'(cnt);
            bus.active_mask = msk;
            bus.latency = LW'(lat);
            bus.stall = stall_pat[cyc];
            step();
        end
        issued_obs = int'(bus.issued_cnt);
        idle_inputs();
    endtask

    initial begin
        int d, iss, rc, rl;
        logic [511:0] rm;

        vecs[0] = '{4, 512'hF, 3, 0, 0, 10, 4};
        vecs[1] = '{6, 512'h29, 2, 0, 0, 11, 3};
        vecs[2] = '{4, 512'hF, 2, 4, 3, 12, 4};
        vecs[3] = '{1, 512'h1, 0, 0, 0, 4, 1};
        vecs[4] = '{0, 512'h0, 5, 0, 0, 1, 0};
        vecs[5] = '{2, '1, 40, 0, 0, 37, 2};
        vecs[6] = '{600, '1, 1, 0, 0, 516, 512};

        idle_inputs();
        bus.tid_count = '0;
        bus.active_mask = '0;
        bus.latency = '0;
        step();
        step();
        chk("rst_out_tid", bus.out_tid, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_pipe_clr", bus.pipe_clr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_issued", bus.issued_cnt, 0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 7; v++) begin
            run_case(vecs[v].cnt, vecs[v].msk, vecs[v].lat,
                     vecs[v].st0, vecs[v].stlen, 0, d, iss);
            chk($sformatf("vec%0d_done_cycle", v), d, vecs[v].exp_done);
            chk($sformatf("vec%0d_issued", v), iss, vecs[v].exp_issued);
        end

        // abort while tid 2 of 8 is in flight
        bus.tid_count = 10'd8;
        bus.active_mask = '1;
        bus.latency = 6'd4;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 1; i < 5; i++) step();
        chk("abort_pre_valid", bus.out_valid, 1);
        chk("abort_pre_tid", bus.out_tid, 2);
        chk("abort_pre_issued", bus.issued_cnt, 3);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_pipe_clr", bus.pipe_clr, 1);
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_issued", bus.issued_cnt, 3);
        chk("abort_done", bus.done, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("abort_after_done", bus.done, 0);
            chk("abort_after_clr", bus.pipe_clr, 0);
        end
        run_case(3, 512'h7, 0, 0, 0, 0, d, iss);
        chk("post_abort_done", d, 6);
        chk("post_abort_issued", iss, 3);

        // start and abort together in IDLE: abort wins
        bus.tid_count = 10'd3;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        idle_inputs();
        chk("sa_busy", bus.busy, 0);
        chk("sa_pipe_clr", bus.pipe_clr, 0);

        // abort during DONE is a no-op
        bus.tid_count = 10'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("zc_done", bus.done, 1);
        chk("zc_clr", bus.pipe_clr, 0);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("dabort_clr", bus.pipe_clr, 0);
        chk("dabort_busy", bus.busy, 0);

        // start while busy ignored, then reset mid-DRAIN
        bus.tid_count = 10'd2;
        bus.active_mask = 512'h3;
        bus.latency = 6'd10;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.start = 1'b1;
        bus.tid_count = 10'd1;
        bus.latency = 6'd0;
        step();
        bus.start = 1'b0;
        chk("busy_start_clr", bus.pipe_clr, 0);
        chk("busy_start_valid", bus.out_valid, 1);
        chk("busy_start_tid", bus.out_tid, 1);
        chk("busy_start_issued", bus.issued_cnt, 2);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_valid", bus.out_valid, 0);
        chk("mrst_tid", bus.out_tid, 0);
        chk("mrst_issued", bus.issued_cnt, 0);
        chk("mrst_done", bus.done, 0);
        chk("mrst_clr", bus.pipe_clr, 0);
        bus.tid_count = 10'd1;
        bus.active_mask = 512'h1;
        bus.latency = 6'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("restart_clr", bus.pipe_clr, 1);
        chk("restart_busy", bus.busy, 1);
        step();
        step();
        chk("restart_valid", bus.out_valid, 1);
        step();
        chk("restart_done", bus.done, 1);
        chk("restart_issued", bus.issued_cnt, 1);
        step();

        for (int r = 0; r < 25; r++) begin
            rc = $urandom_range(0, 24);
            if (r == 3) rc = 1000;
            rl = $urandom_range(0, 36);
            for (int w = 0; w < 16; w++) rm[w * 32 +: 32] = $urandom();
            run_case(rc, rm, rl, 0, 0, 30, d, iss);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
